hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Tracks in-flight destination registers across the EXE, LS and WB stages using a 3-slot shift scoreboard.
- For the instruction in ID, produces per-operand forwarding selects (e_data_hazard) and a load-use stall request.
- Sits between decode (producer of rs/rd, wb_sel) and the EXE operand muxes feeding the ALU.
- Inserts bubbles on stall/flush and freezes on external pipeline hold.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 32, performance counter width (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID stage holds a valid instruction.
- id_rs1_i  in  REG_ADDR_W  source register 1 address.
- id_rs2_i  in  REG_ADDR_W  source register 2 address.
- id_rs1_used_i  in  1  instruction reads rs1.
- id_rs2_used_i  in  1  instruction reads rs2.
- id_rd_i  in  REG_ADDR_W  destination address.
- id_rd_we_i  in  1  instruction writes rd.
- id_wb_sel_i  in  e_regfile_wb_sel  writeback source; WB_MEM_LOAD marks a load.
- freeze_i  in  1  global pipeline hold (multi-cycle unit busy, memory wait).
- flush_i  in  1  branch taken / redirect; kills the ID instruction.
- fwd_a_sel_o  out  e_data_hazard  operand A (rs1) forward select.
- fwd_b_sel_o  out  e_data_hazard  operand B (rs2) forward select.
- load_use_stall_o  out  1  hold PC/IF/ID and bubble EXE.

Behaviour:
- Scoreboard slots EXE, LS, WB, each holding {valid, rd, we, is_load}. is_load = (id_wb_sel_i == WB_MEM_LOAD).
- Reset (async, rstn=0): all slot valid bits are 0. Outputs during and after reset until a new instruction arrives: fwd_a/b = NO_HAZARD, load_use_stall_o = 0.
- Reset asserted mid-operation clears all slots immediately, with no partial shift.
- Slot "hit" for an operand: slot.valid & slot.we & slot.rd != 0 & operand_used & operand_addr == slot.rd. x0 is never forwarded or stalled on.
- load_use_stall_o (combinational) = id_valid_i & !flush_i & EXE hit on rs1 or rs2 & EXE.is_load.
- Forward select per operand (combinational):
  - NO_HAZARD when !id_valid_i, load_use_stall_o or flush_i is asserted.
  - Otherwise, in priority order: EXE hit (non-load) -> FROM_EXE; else LS hit -> FROM_LS; else WB hit -> FROM_WB; else NO_HAZARD.
  - The youngest producer always wins.
- Sequential update on rising clk:
  - If freeze_i=1: all slots hold, regardless of flush_i or stall. Upstream holds flush_i until the freeze is released.
  - Else: WB <= LS; LS <= EXE; EXE <= ID entry when id_valid_i & !load_use_stall_o & !flush_i, otherwise a bubble (valid=0).
- Latency:
  - Selects and stall are zero-cycle, i.e. valid in the same cycle as the ID inputs.
  - A load hitting EXE causes exactly 1 stall cycle (freeze_i=0). The next cycle the load sits in LS and the select is FROM_LS.
- A producer leaves the scoreboard 3 non-frozen cycles after entering EXE. The regfile is write-through, so no 4th stage is tracked.
- The ID instruction never matches against itself. rd == rs of the same instruction has no effect.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt_o and perf_fwd_cnt_o, both CNT_W wide and reset to 0.
  - perf_stall_cnt_o increments each non-frozen cycle with load_use_stall_o=1.
  - perf_fwd_cnt_o increments by 0, 1 or 2 each non-frozen cycle, by the number of operands whose select != NO_HAZARD.
  - Both counters wrap modulo 2^CNT_W and hold while freeze_i=1.
- Undefined: the ports and logic are absent; the core behaviour is identical.

Test Plan:
- Back-to-back dependency: add x5 (in EXE), then ID reads rs1=x5 -> fwd_a_sel_o=FROM_EXE, stall=0. Next cycle ID reads rs2=x5 -> fwd_b_sel_o=FROM_LS. Cycle after -> FROM_WB. One cycle later -> NO_HAZARD.
- Load-use: lw x7 in EXE, ID reads rs2=x7 -> load_use_stall_o=1 for exactly 1 cycle, EXE gets a bubble. Next cycle fwd_b_sel_o=FROM_LS, stall=0.
- Priority and x0: EXE and LS both write x3, ID reads x3 -> FROM_EXE. Producers write x0 and ID reads x0 -> NO_HAZARD, stall=0.
- Freeze: producer of x9 in EXE, freeze_i=1 for 4 cycles -> fwd_a_sel_o stays FROM_EXE throughout. After release it advances to FROM_LS.
- Flush with load-use pending: lw x4 in EXE, ID reads x4, flush_i=1 -> stall=0, selects NO_HAZARD, next EXE is a bubble. Assert rstn=0 mid-sequence -> all outputs revert to NO_HAZARD/0 asynchronously.
- With HAZARD_PERF_CNT_EN: run the load-use and dependency scenarios -> perf_stall_cnt_o=1, perf_fwd_cnt_o equals the number of forwarded operands (4). Preload the counter to all-ones and trigger one stall -> wraps to 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use hazard unit tracking EXE/LS/WB destinations.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.

package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    WB_ALU      = 2'd0,
    WB_MEM_LOAD = 2'd1,
    WB_PC4      = 2'd2,
    WB_CSR      = 2'd3
  } e_regfile_wb_sel;

  typedef enum logic [1:0] {
    NO_HAZARD = 2'd0,
    FROM_EXE  = 2'd1,
    FROM_LS   = 2'd2,
    FROM_WB   = 2'd3
  } e_data_hazard;

endpackage

module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  input  e_regfile_wb_sel       id_wb_sel_i,
  input  logic                  freeze_i,
  input  logic                  flush_i,
  output e_data_hazard          fwd_a_sel_o,
  output e_data_hazard          fwd_b_sel_o,
  output logic                  load_use_stall_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt_o,
  output logic [CNT_W-1:0]      perf_fwd_cnt_o
`endif
);

  // Elaboration-time parameter sanity
  if (REG_ADDR_W < 1) begin : g_bad_addr_w
    $error("REG_ADDR_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } slot_t;

  slot_t exe_q, ls_q, wb_q;
  slot_t id_entry;
  logic  id_advance;

  logic exe_hit_a, ls_hit_a, wb_hit_a;
  logic exe_hit_b, ls_hit_b, wb_hit_b;

  // A slot hit needs a real writer of a nonzero register that the operand reads
  function automatic logic slot_hit(input slot_t s, input logic used,
                                    input logic [REG_ADDR_W-1:0] addr);
    return s.valid & s.we & (s.rd != '0) & used & (addr == s.rd);
  endfunction

  // Youngest producer wins
  function automatic e_data_hazard pick_sel(input logic e_hit, input logic l_hit,
                                            input logic w_hit);
    if (e_hit)      return FROM_EXE;
    else if (l_hit) return FROM_LS;
    else if (w_hit) return FROM_WB;
    else            return NO_HAZARD;
  endfunction

  assign exe_hit_a = slot_hit(exe_q, id_rs1_used_i, id_rs1_i);
  assign ls_hit_a  = slot_hit(ls_q,  id_rs1_used_i, id_rs1_i);
  assign wb_hit_a  = slot_hit(wb_q,  id_rs1_used_i, id_rs1_i);
  assign exe_hit_b = slot_hit(exe_q, id_rs2_used_i, id_rs2_i);
  assign ls_hit_b  = slot_hit(ls_q,  id_rs2_used_i, id_rs2_i);
  assign wb_hit_b  = slot_hit(wb_q,  id_rs2_used_i, id_rs2_i);

  // Hazard detection and forward selects for the ID instruction
  always_comb begin
    load_use_stall_o = 1'b0;
    fwd_a_sel_o      = NO_HAZARD;
    fwd_b_sel_o      = NO_HAZARD;
    id_advance       = 1'b0;

    load_use_stall_o = id_valid_i & ~flush_i & exe_q.is_load & (exe_hit_a | exe_hit_b);
    id_advance       = id_valid_i & ~flush_i & ~load_use_stall_o;

    if (id_advance) begin
      fwd_a_sel_o = pick_sel(exe_hit_a, ls_hit_a, wb_hit_a);
      fwd_b_sel_o = pick_sel(exe_hit_b, ls_hit_b, wb_hit_b);
    end
  end

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = id_rd_i;
    id_entry.we      = id_rd_we_i;
    id_entry.is_load = (id_wb_sel_i == WB_MEM_LOAD);
  end

  // Scoreboard shift; stalled or flushed cycles inject a bubble into EXE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exe_q <= '0;
      ls_q  <= '0;
      wb_q  <= '0;
    end else if (!freeze_i) begin
      wb_q  <= ls_q;
      ls_q  <= exe_q;
      exe_q <= id_advance ? id_entry : '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [1:0] fwd_inc;

  always_comb begin
    fwd_inc = 2'(fwd_a_sel_o != NO_HAZARD) + 2'(fwd_b_sel_o != NO_HAZARD);
  end

  // Free-running event counters, wrap naturally, hold while frozen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt_o <= '0;
      perf_fwd_cnt_o   <= '0;
    end else if (!freeze_i) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + CNT_W'(load_use_stall_o);
      perf_fwd_cnt_o   <= perf_fwd_cnt_o + CNT_W'(fwd_inc);
    end
  end
`endif

endmodule
